// File: rtl/result_reader_pkg.sv
// result_reader_pkg: shared types and constants for the result reader.
//   state_e     - reader FSM state encoding (3 bits)
//   IDX_W       - width of the word index seen by the sink
//   N_WORDS_DEF - default number of result registers
//   WIDTH_DEF   - default result word width
package result_reader_pkg;

  localparam int unsigned IDX_W       = 5;
  localparam int unsigned N_WORDS_DEF = 16;
  localparam int unsigned WIDTH_DEF   = 12;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StWaitEnd = 3'd1,
    StSnap    = 3'd2,
    StSend    = 3'd3,
    StDone    = 3'd4
  } state_e;

endpackage

// File: rtl/result_reader_if.sv
// result_reader_if: valid/ready result stream from the reader to a host-side sink.
//   out_data  - current result word
//   out_idx   - index of the current word (0 = r1)
//   out_valid - data/idx/last are valid
//   out_ready - sink accepts the word this cycle
//   out_last  - final word of the stream
// master: the reader (drives data/idx/valid/last). slave: the sink (drives ready).
interface result_reader_if #(
  parameter int unsigned WIDTH = result_reader_pkg::WIDTH_DEF
) ();

  logic [WIDTH-1:0]                   out_data;
  logic [result_reader_pkg::IDX_W-1:0] out_idx;
  logic                               out_valid;
  logic                               out_ready;
  logic                               out_last;

  modport master (
    output out_data,
    output out_idx,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_idx,
    input  out_valid,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/completion_tracker.sv
// completion_tracker: sticky OR of per-core completion flags.
//   clk_i      - clock
//   rst_i      - synchronous active-high reset
//   clr_i      - clear all sticky flags (has priority over accumulate)
//   en_i       - accumulate end_i into the sticky flags
//   end_i      - per-core completion flags
//   all_done_o - every core has finished (sticky flags OR the current flags)
module completion_tracker #(
  parameter int unsigned N_CORES = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic [N_CORES-1:0] end_i,
  output logic               all_done_o
);

  logic [N_CORES-1:0] sticky_q, sticky_d;

  always_comb begin
    sticky_d = sticky_q;
    if (clr_i) begin
      sticky_d = '0;
    end else if (en_i) begin
      sticky_d = sticky_q | end_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  // Include the live flags so the last finisher is seen in its own cycle.
  assign all_done_o = &(sticky_q | end_i);

endmodule

// File: rtl/result_reader.sv
// result_reader: waits for every core to finish, snapshots the result registers and
// streams them word by word to a host sink.
//   clk           - clock, rising edge
//   rst           - synchronous active-high reset
//   start_process - arms the reader (level in IDLE, rising edge elsewhere)
//   end_process   - per-core completion flags
//   res_flat      - r1..rN packed, r1 in the low word
//   out_if        - result stream (master side)
//   busy          - high while waiting, snapshotting or sending
//   done          - high once the stream has completed
// Optional feature: define RESULT_CHECKSUM_EN to append a checksum word (sum of all
// snapshot words mod 2^WIDTH, idx = N_WORDS) carrying out_last.
module result_reader
  import result_reader_pkg::*;
#(
  parameter int unsigned N_CORES = 4,
  parameter int unsigned N_WORDS = N_WORDS_DEF,
  parameter int unsigned WIDTH   = WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_process,
  input  logic [N_CORES-1:0]       end_process,
  input  logic [N_WORDS*WIDTH-1:0] res_flat,
  result_reader_if.master          out_if,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned SelW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
`ifdef RESULT_CHECKSUM_EN
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_WORDS);
`else
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_WORDS - 1);
`endif

  state_e             state_q, state_d;
  logic               start_q;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   snap_q [N_WORDS];
  logic [WIDTH-1:0]   snap_d [N_WORDS];
`ifdef RESULT_CHECKSUM_EN
  logic [WIDTH-1:0]   csum_q, csum_d;
`endif

  logic               start_rise;
  logic               trk_clr, trk_en, all_done;
  logic [IDX_W-1:0]   idx_nxt;
  logic [WIDTH-1:0]   word_nxt;

  completion_tracker #(
    .N_CORES (N_CORES)
  ) u_tracker (
    .clk_i      (clk),
    .rst_i      (rst),
    .clr_i      (trk_clr),
    .en_i       (trk_en),
    .end_i      (end_process),
    .all_done_o (all_done)
  );

  assign start_rise = start_process & ~start_q;
  assign idx_nxt    = idx_q + IDX_W'(1);

  // Word presented after the current one is accepted.
  always_comb begin
    word_nxt = '0;
    if (idx_nxt < IDX_W'(N_WORDS)) begin
      word_nxt = snap_q[idx_nxt[SelW-1:0]];
    end
`ifdef RESULT_CHECKSUM_EN
    else begin
      word_nxt = csum_q;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    snap_d  = snap_q;
`ifdef RESULT_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    trk_clr = 1'b0;
    trk_en  = 1'b0;

    unique case (state_q)
      StIdle: begin
        trk_clr = 1'b1;
        if (start_process) begin
          state_d = StWaitEnd;
        end
      end
      StWaitEnd: begin
        // A fresh start restarts the wait from scratch.
        if (start_rise) begin
          trk_clr = 1'b1;
        end else begin
          trk_en = 1'b1;
          if (all_done) begin
            state_d = StSnap;
          end
        end
      end
      StSnap: begin
        for (int unsigned k = 0; k < N_WORDS; k++) begin
          snap_d[k] = res_flat[k*WIDTH +: WIDTH];
        end
`ifdef RESULT_CHECKSUM_EN
        csum_d = '0;
        for (int unsigned k = 0; k < N_WORDS; k++) begin
          csum_d = csum_d + res_flat[k*WIDTH +: WIDTH];
        end
`endif
        // First word comes straight from the bus since snap_q loads on this same edge.
        idx_d   = '0;
        data_d  = res_flat[WIDTH-1:0];
        valid_d = 1'b1;
        last_d  = (LastIdx == '0);
        state_d = StSend;
      end
      StSend: begin
        if (valid_q && out_if.out_ready) begin
          if (idx_q == LastIdx) begin
            state_d = StDone;
            valid_d = 1'b0;
            last_d  = 1'b0;
            data_d  = '0;
            idx_d   = '0;
          end else begin
            idx_d  = idx_nxt;
            data_d = word_nxt;
            last_d = (idx_nxt == LastIdx);
          end
        end
      end
      StDone: begin
        if (start_rise) begin
          trk_clr = 1'b1;
          state_d = StWaitEnd;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d == StWaitEnd) || (state_d == StSnap) || (state_d == StSend);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      start_q <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int unsigned k = 0; k < N_WORDS; k++) begin
        snap_q[k] <= '0;
      end
`ifdef RESULT_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      start_q <= start_process;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      for (int unsigned k = 0; k < N_WORDS; k++) begin
        snap_q[k] <= snap_d[k];
      end
`ifdef RESULT_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign out_if.out_data  = data_q;
  assign out_if.out_idx   = idx_q;
  assign out_if.out_valid = valid_q;
  assign out_if.out_last  = last_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule

// File: tb/tb_result_reader.sv
// tb_result_reader: randomized scoreboard bench for result_reader.
// Expected words are queued when the final end flag is driven; a negedge monitor pops
// and compares on every handshake and checks hold-stability under backpressure.
module tb_result_reader;
  import result_reader_pkg::*;

  localparam int NW = 16;
  localparam int W  = 12;
  localparam int NC = 4;
`ifdef RESULT_CHECKSUM_EN
  localparam int NOUT = NW + 1;
`else
  localparam int NOUT = NW;
`endif

  typedef struct packed {
    logic [W-1:0] data;
    logic [4:0]   idx;
    logic         last;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            start_process;
  logic [NC-1:0]   end_process;
  logic [NW*W-1:0] res_flat;
  logic            busy;
  logic            done;

  result_reader_if #(.WIDTH(W)) out_if ();

  result_reader #(
    .N_CORES (NC),
    .N_WORDS (NW),
    .WIDTH   (W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_process (start_process),
    .end_process   (end_process),
    .res_flat      (res_flat),
    .out_if        (out_if),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          hs_count = 0;
  int          valid_cycles = 0;
  int          stall_cycles = 0;
  int          ready_mode = 0;
  int unsigned words[NW];
  logic        prev_stall = 1'b0;
  exp_t        prev_out;
  exp_t        mon_e;

  function automatic void check(string name, longint act, longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endfunction

  function automatic void set_res();
    for (int k = 0; k < NW; k++) res_flat[k*W +: W] = W'(words[k]);
  endfunction

  // Reference model: the stream is the snapshot in order, optionally followed by the
  // modular sum, with last on the final entry.
  function automatic void push_expected();
    int unsigned sum = 0;
    exp_t e;
    for (int k = 0; k < NW; k++) begin
      e.data = W'(words[k]);
      e.idx  = 5'(k);
      e.last = (k == NOUT - 1);
      exp_q.push_back(e);
      sum += words[k];
    end
    if (NOUT > NW) begin
      e.data = W'(sum % 4096);
      e.idx  = 5'(NW);
      e.last = 1'b1;
      exp_q.push_back(e);
    end
  endfunction

  always @(negedge clk) begin
    if (prev_stall) begin
      check("hold_valid", out_if.out_valid, 1);
      check("hold_data", out_if.out_data, prev_out.data);
      check("hold_idx", out_if.out_idx, prev_out.idx);
      check("hold_last", out_if.out_last, prev_out.last);
    end
    prev_stall    = out_if.out_valid && !out_if.out_ready && !rst;
    prev_out.data = out_if.out_data;
    prev_out.idx  = out_if.out_idx;
    prev_out.last = out_if.out_last;
    if (out_if.out_valid && !rst) begin
      valid_cycles++;
      if (!out_if.out_ready) stall_cycles++;
    end
    if (out_if.out_valid && out_if.out_ready && !rst) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("word_data", out_if.out_data, mon_e.data);
        check("word_idx", out_if.out_idx, mon_e.idx);
        check("word_last", out_if.out_last, mon_e.last);
      end
      hs_count++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    case (ready_mode)
      0: out_if.out_ready = 1'b1;
      1: out_if.out_ready = ~out_if.out_ready;
      2: out_if.out_ready = 1'($urandom_range(0, 1));
      default: out_if.out_ready = 1'b0;
    endcase
  endtask

  task automatic arm();
    start_process = 1'b0;
    step();
    start_process = 1'b1;
    step();
  endtask

  task automatic run_stream(input int mode, input bit stagger, input bit post_change,
                            input bit toggle_start);
    int n;
    int v0;
    int s0;
    arm();
    ready_mode = mode;
    repeat (3) step();
    set_res();
    push_expected();
    if (stagger) begin
      for (int i = 0; i < NC - 1; i++) begin
        repeat ($urandom_range(2, 9)) step();
        end_process = NC'(1 << i);
        step();
        end_process = '0;
      end
      repeat ($urandom_range(2, 9)) step();
      check("no_early_valid", out_if.out_valid, 0);
      check("waiting_busy", busy, 1);
      end_process = NC'(1 << (NC - 1));
    end else begin
      end_process = '1;
    end
    v0 = valid_cycles;
    s0 = stall_cycles;
    step();
    end_process = '0;
    check("snap_cycle_valid", out_if.out_valid, 0);
    check("snap_cycle_busy", busy, 1);
    step();
    check("first_word_valid", out_if.out_valid, 1);
    if (post_change) begin
      words[0] = 32'hFFF;
      set_res();
    end
    if (toggle_start) begin
      start_process = 1'b0;
      step();
      start_process = 1'b1;
    end
    n = 0;
    while (!done && n < 200) begin
      step();
      n++;
    end
    check("done_reached", done, 1);
    check("busy_after", busy, 0);
    check("valid_after", out_if.out_valid, 0);
    check("words_left", exp_q.size(), 0);
    check("send_cycles", valid_cycles - v0, NOUT + (stall_cycles - s0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int n;
    rst = 1'b1;
    start_process = 1'b0;
    end_process = '0;
    res_flat = '0;
    out_if.out_ready = 1'b0;
    repeat (3) step();
    check("rst_valid", out_if.out_valid, 0);
    check("rst_data", out_if.out_data, 0);
    check("rst_idx", out_if.out_idx, 0);
    check("rst_last", out_if.out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    step();

    // Basic readout, simultaneous finish.
    for (int k = 0; k < NW; k++) words[k] = 32'h100 + k;
    run_stream(0, 1'b0, 1'b0, 1'b0);

    // Staggered finish after re-arm (sticky flags must have been cleared).
    for (int k = 0; k < NW; k++) words[k] = $urandom_range(0, 4095);
    run_stream(0, 1'b1, 1'b0, 1'b0);

    // Alternating backpressure with a start toggle mid-stream that must be ignored.
    for (int k = 0; k < NW; k++) words[k] = $urandom_range(0, 4095);
    run_stream(1, 1'b1, 1'b0, 1'b1);

    // Result change right after the snapshot must not leak into the stream.
    for (int k = 0; k < NW; k++) words[k] = 32'h100 + k;
    words[0] = 32'h101;
    run_stream(2, 1'b0, 1'b1, 1'b0);

    // Random traffic.
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < NW; k++) words[k] = $urandom_range(0, 4095);
      run_stream(2, r[0], 1'b0, 1'b0);
    end

    // All-ones words (checksum wraps when enabled).
    for (int k = 0; k < NW; k++) words[k] = 32'hFFF;
    run_stream(0, 1'b0, 1'b0, 1'b0);

    // Reset mid-stream after word 7 is accepted.
    for (int k = 0; k < NW; k++) words[k] = $urandom_range(0, 4095);
    arm();
    ready_mode = 0;
    repeat (3) step();
    set_res();
    push_expected();
    base = hs_count;
    end_process = '1;
    step();
    end_process = '0;
    n = 0;
    while (hs_count - base < 8 && n < 50) begin
      step();
      n++;
    end
    check("reset_point_reached", hs_count - base, 8);
    rst = 1'b1;
    start_process = 1'b0;
    ready_mode = 3;
    out_if.out_ready = 1'b0;
    step();
    check("midrst_valid", out_if.out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_last", out_if.out_last, 0);
    exp_q.delete();
    rst = 1'b0;
    step();
    check("idle_stays_quiet", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
